// File: rtl/uart_in_block_if.sv
// CPU/memory-side bundle of the IN block: request handshake, serial input
// and the memory write port.
interface uart_in_block_if;
  logic        start;
  logic [11:0] addressin;
  logic        rx;
  logic [29:0] out;
  logic [11:0] addressout;
  logic        write;
  logic        stop;
  logic        done;
  logic        busy;
  logic        framing_err;

  modport master (
    output start, addressin, rx,
    input  out, addressout, write, stop, done, busy, framing_err
  );

  modport slave (
    input  start, addressin, rx,
    output out, addressout, write, stop, done, busy, framing_err
  );
endinterface

// File: rtl/uart_in_block.sv
// IN device: 8N1 receiver feeding a 5x6-bit word packer that writes
// BLOCK_WORDS words per request, with one queued follow-on request.
module uart_in_block #(
  parameter int CLKS_PER_BIT = 217,
  parameter int BLOCK_WORDS  = 10
) (
  input logic           clk,
  input logic           reset,
  uart_in_block_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        byte_valid_q;
  logic [5:0]  mix_q;
  logic        framing_err_q;

  logic        busy_q, write_q, stop_q, done_q, pending_q;
  logic [2:0]  byte_idx_q;
  logic [3:0]  word_cnt_q;
  logic [11:0] addr_q, next_addr_q;
  logic [29:0] word_q, out_q;
  logic [29:0] word_d;
  logic        block_end_d, start_idle_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      baud_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_valid_q  <= 1'b0;
      mix_q         <= '0;
      framing_err_q <= 1'b0;
    end else begin
      rx_meta_q     <= bus.rx;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_sync_q;
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            baud_cnt_q <= '0;
          end
        end
        RX_START: begin
          if (baud_cnt_q == HALF_BIT) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            // a high level at mid start bit was only a glitch
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt_q == FULL_BIT) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                   bit_idx_q  <= bit_idx_q + 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt_q == FULL_BIT) begin
            baud_cnt_q <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
              mix_q        <= shift_q[5:0];
            end else begin
              framing_err_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Byte 0 lands in the top field, byte 4 in the bottom one.
  for (genvar gi = 0; gi < 5; gi++) begin : g_field
    assign word_d[29-6*gi -: 6] = (byte_idx_q == 3'(gi)) ? mix_q : word_q[29-6*gi -: 6];
  end

  assign block_end_d  = write_q && ((word_cnt_q + 4'd1) == 4'(BLOCK_WORDS));
  // an idle start also covers a start landing on a block end with nothing queued
  assign start_idle_d = bus.start && (!busy_q || (block_end_d && !pending_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= 1'b0;
      write_q     <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      pending_q   <= 1'b0;
      byte_idx_q  <= '0;
      word_cnt_q  <= '0;
      addr_q      <= '0;
      next_addr_q <= '0;
      word_q      <= '0;
      out_q       <= '0;
    end else begin
      write_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;

      if (busy_q && byte_valid_q) begin
        word_q <= word_d;
        if (byte_idx_q == 3'd4) begin
          write_q    <= 1'b1;
          out_q      <= word_d;
          byte_idx_q <= '0;
        end else begin
          byte_idx_q <= byte_idx_q + 1'b1;
        end
      end

      if (write_q) begin
        addr_q     <= addr_q + 12'd1;
        word_cnt_q <= word_cnt_q + 4'd1;
        if (block_end_d) begin
          done_q <= 1'b1;
          if (pending_q) begin
            stop_q     <= 1'b1;
            addr_q     <= next_addr_q;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            pending_q  <= 1'b0;
          end else if (!bus.start) begin
            busy_q <= 1'b0;
          end
        end
      end

      if (bus.start) begin
        if (start_idle_d) begin
          busy_q     <= 1'b1;
          stop_q     <= 1'b1;
          addr_q     <= bus.addressin;
          word_cnt_q <= '0;
          byte_idx_q <= '0;
        end else begin
          next_addr_q <= bus.addressin;
          pending_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.addressout  = addr_q;
  assign bus.write       = write_q;
  assign bus.stop        = stop_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.framing_err = framing_err_q;

endmodule

// File: tb/tb_uart_in_block.sv
// Random and directed serial traffic against a transaction-level model of
// request/block/word behaviour for uart_in_block.
module tb_uart_in_block;
  localparam int CPB = 4;
  localparam int BW  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_in_block_if bus();

  uart_in_block #(.CLKS_PER_BIT(CPB), .BLOCK_WORDS(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observed events
  logic [41:0] got_q[$];
  int n_stop = 0, n_done = 0, n_ferr = 0, n_done_stop = 0;
  logic [11:0] last_wr_addr = '0;
  logic [29:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.write) begin
        got_q.push_back({bus.addressout, bus.out});
        last_wr_addr = bus.addressout;
        last_wr_data = bus.out;
      end
      if (bus.stop)              n_stop++;
      if (bus.done)              n_done++;
      if (bus.stop && bus.done)  n_done_stop++;
      if (bus.framing_err)       n_ferr++;
    end
  end

  // Reference model: tracks requests, bytes and words, not cycles
  logic [41:0] exp_q[$];
  int exp_stop = 0, exp_done = 0, exp_ferr = 0, exp_done_stop = 0;
  bit m_busy, m_pending;
  int m_addr, m_next, m_cnt, m_idx;
  int m_bytes[5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pending = 0; m_addr = 0; m_next = 0; m_cnt = 0; m_idx = 0;
  endtask

  task automatic model_start(input int a);
    if (!m_busy) begin
      m_busy = 1; m_addr = a; m_cnt = 0; m_idx = 0;
      exp_stop++;
    end else begin
      m_pending = 1; m_next = a;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    int w;
    if (!good) begin
      exp_ferr++;
      return;
    end
    if (!m_busy) return;
    m_bytes[m_idx] = int'(b) % 64;
    m_idx++;
    if (m_idx == 5) begin
      w = 0;
      for (int k = 0; k < 5; k++) w = w + m_bytes[k] * (1 << (6 * (4 - k)));
      exp_q.push_back({12'(m_addr), 30'(w)});
      m_idx = 0;
      m_addr = (m_addr + 1) % 4096;
      m_cnt++;
      if (m_cnt == BW) begin
        exp_done++;
        if (m_pending) begin
          m_addr = m_next; m_cnt = 0; m_pending = 0;
          exp_stop++; exp_done_stop++;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good);
    drive_bit(1'b1);
    model_byte(b, good);
  endtask

  task automatic do_start(input logic [11:0] a);
    logic exp_s;
    exp_s = !m_busy;
    bus.start = 1'b1;
    bus.addressin = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("stop_after_start", {31'd0, bus.stop}, {31'd0, exp_s});
    model_start(int'(a));
  endtask

  task automatic checkpoint(input string tag);
    logic [41:0] g, e;
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_nwrites"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check_eq({tag, "_wr_addr"}, {20'd0, g[41:30]}, {20'd0, e[41:30]});
      check_eq({tag, "_wr_data"}, {2'd0, g[29:0]}, {2'd0, e[29:0]});
    end
    got_q.delete();
    exp_q.delete();
    check_eq({tag, "_stops"}, n_stop, exp_stop);
    check_eq({tag, "_dones"}, n_done, exp_done);
    check_eq({tag, "_ferrs"}, n_ferr, exp_ferr);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, m_busy});
    check_eq({tag, "_addr"}, {20'd0, bus.addressout}, 32'(m_addr));
  endtask

  initial begin
    logic [7:0] b;
    int guard;
    bus.start = 1'b0;
    bus.addressin = '0;
    bus.rx = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_out", {2'd0, bus.out}, 32'd0);
    check_eq("rst_addr", {20'd0, bus.addressout}, 32'd0);
    check_eq("rst_write", {31'd0, bus.write}, 32'd0);
    check_eq("rst_stop", {31'd0, bus.stop}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_ferr", {31'd0, bus.framing_err}, 32'd0);

    // Byte while idle is discarded
    send_frame(8'h2A, 1'b1);
    checkpoint("idle");

    // Basic word, then a word of ignored upper bits
    do_start(12'h100);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check_eq("t1_data", {2'd0, last_wr_data}, 32'h0108_3105);
    check_eq("t1_waddr", {20'd0, last_wr_addr}, 32'h100);
    checkpoint("t1");
    for (int i = 0; i < 5; i++) send_frame((i % 2 == 0) ? 8'hC0 : 8'h00, 1'b1);
    check_eq("t1b_data", {2'd0, last_wr_data}, 32'd0);
    checkpoint("t1b");

    // All-ones block across the address wrap
    do_start(12'hFFF);
    for (int i = 0; i < 10; i++) send_frame(8'h3F, 1'b1);
    check_eq("wrap_data", {2'd0, last_wr_data}, 32'h3FFF_FFFF);
    check_eq("wrap_waddr", {20'd0, last_wr_addr}, 32'h000);
    checkpoint("wrap");

    // Queued request takes over at block end
    do_start(12'h300);
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    checkpoint("pend1");
    do_start(12'h200);
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    checkpoint("pend2");
    check_eq("done_with_stop", n_done_stop, exp_done_stop);
    for (int i = 0; i < 10; i++) send_frame(8'($urandom), 1'b1);
    check_eq("pend_waddr", {20'd0, last_wr_addr}, 32'h201);
    checkpoint("pend3");

    // Framing error in the middle of a word
    do_start(12'h050);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b0);
    send_frame(8'h04, 1'b1);
    send_frame(8'h05, 1'b1);
    check_eq("ferr_nowrite", got_q.size(), 0);
    send_frame(8'h06, 1'b1);
    checkpoint("ferr");
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    checkpoint("ferr2");

    // Reset in the middle of the fourth frame of a word
    do_start(12'h400);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    reset = 1'b0;
    model_reset();
    check_eq("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("mrst_write", {31'd0, bus.write}, 32'd0);
    checkpoint("mrst");
    do_start(12'h555);
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    checkpoint("mrst2");
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    checkpoint("mrst3");

    // Randomised blocks with occasional queued requests and bad frames
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 2) == 0) send_frame(8'($urandom), 1'b1);
      do_start(12'($urandom));
      guard = 0;
      while (m_busy && guard < 60) begin
        b = 8'($urandom);
        send_frame(b, $urandom_range(0, 7) != 0);
        guard++;
        if (m_idx == 0 && m_busy && !m_pending && $urandom_range(0, 3) == 0)
          do_start(12'($urandom));
      end
      checkpoint("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_in_block.md
Name: uart_in_block

Overview:
- Input-device counterpart of the block-output path: receives a serial byte stream, packs 6-bit MIX bytes into 30-bit words, and writes blocks of words into memory.
- Sits between the board rx pin and the memory write port; driven by the CPU IN instruction through a start/stop handshake.
- Contains its own 8N1 UART deserializer, word packer, address counter and block sequencer, with one queued request.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per UART bit (min 4).
- BLOCK_WORDS, 10, words written per IN request (range 1..15).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle IN request pulse from CPU
- addressin  input  12  first memory address of the block for this request
- rx  input  1  asynchronous serial input, idle high
- out  output  30  packed word, valid while write=1
- addressout  output  12  memory write address, valid while write=1
- write  output  1  one-cycle memory write strobe
- stop  output  1  one-cycle pulse: request accepted, CPU may proceed
- done  output  1  one-cycle pulse: block complete
- busy  output  1  a block transfer is in progress
- framing_err  output  1  one-cycle pulse: received frame had stop bit = 0

Behaviour:
- Reset values: out=0, addressout=0, write=0, stop=0, done=0, busy=0, framing_err=0. Internally: byte index=0, word count=0, pending=0, receiver IDLE.
- rx passes through a 2-flop synchronizer before any use.
- Receiver FSM:
  - IDLE: a 1->0 edge on the synchronized rx enters START.
  - START: rx is sampled at CLKS_PER_BIT/2. A 1 there returns to IDLE (glitch rejected); otherwise enter DATA.
  - DATA: 8 bits, LSB first, each sampled one CLKS_PER_BIT after the previous sample.
  - STOP: stop bit sampled one bit time later. Stop=1 gives a byte-valid pulse; stop=0 gives framing_err and the byte is dropped. Either way return to IDLE.
- The MIX byte is data[5:0]; data[7:6] are ignored.
- Bytes arriving while busy=0 are discarded. The receiver still runs so that it stays in frame.
- Packing order, by byte index: 0->word[29:24], 1->[23:18], 2->[17:12], 3->[11:6], 4->[5:0].
- The cycle after the 5th byte is valid: write=1 with out=packed word and addressout=current address. Byte index returns to 0.
- The cycle after write: addressout increments by 1 (12-bit, 4095 wraps to 0) and word count increments.
- Request handshake:
  - start while busy=0: next cycle busy=1, stop=1, addressout=addressin, word count=0, byte index=0.
  - start while busy=1: addressin is latched into next_addr and pending=1. No stop pulse yet. A second start while pending=1 overwrites next_addr.
- Block end: when the word count reaches BLOCK_WORDS after a write, done=1 the following cycle.
  - pending=1: in the same cycle as done, stop=1, addressout=next_addr, word count=0, pending=0; busy stays 1.
  - pending=0: busy=0 in that cycle.
- start in the same cycle as block end with pending=0 is treated as an idle start. It produces a stop pulse one cycle later, and no bytes are lost.
- A framing error mid-word leaves the byte index unchanged (the byte is simply not counted).
- Reset mid-frame or mid-block: all state returns to reset values, the partial word is discarded and the receiver goes to IDLE. The next falling edge starts a fresh frame.

Test Plan:
- CLKS_PER_BIT=4, BLOCK_WORDS=2. start with addressin=0x100, then send bytes 0x01..0x05 -> stop pulse one cycle after start; write=1 with out=0x1083105 and addressout=0x100; addressout becomes 0x101.
- Same setup, send 10 bytes 0x3F each -> two writes, each with out=0x3FFFFFFF, at 0x100 and 0x101. done pulses once, then busy=0. Bytes 0xC0 and 0x00 both pack to field value 0.
- start with addressin=0xFFF, BLOCK_WORDS=2 -> writes at 0xFFF then 0x000 (wrap).
- Second start with addressin=0x200 during block 1 -> no immediate stop. At block-1 end, done and stop pulse together and busy stays 1; the next write goes to 0x200.
- Send a frame with stop bit=0 mid-word -> framing_err pulse, no write. The following 5 good bytes pack correctly from the current byte index.
- Assert reset after 3 bytes of a word -> busy=0 and no write. After restart, 5 new bytes produce one correct word at the new addressin.
